// File: rtl/fp_operand_unpack.sv
// rtl/fp_operand_unpack.sv - IEEE-754 single operand-pair unpacker with a 2-entry output buffer
module fp_operand_unpack #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sa,
    output logic        sb,
    output logic [7:0]  ea,
    output logic [7:0]  eb,
    output logic [23:0] ma,
    output logic [23:0] mb,
    output logic [1:0]  fa,
    output logic [1:0]  fb,
    output logic [7:0]  nan_cnt
);

    // Class codes shared with the result packer
    localparam logic [1:0] CLS_INF  = 2'b00;
    localparam logic [1:0] CLS_NAN  = 2'b01;
    localparam logic [1:0] CLS_ZERO = 2'b10;
    localparam logic [1:0] CLS_NORM = 2'b11;

    // One decoded operand: {sign, exp, significand, class}
    localparam int OW = 35;

    function automatic logic [OW-1:0] unpack(input logic [31:0] x);
        logic [7:0]  exp_f;
        logic [22:0] frac_f;
        exp_f  = x[30:23];
        frac_f = x[22:0];
        if (exp_f == 8'd0) begin
            // Denormals flush to zero but keep their sign
            unpack = {x[31], 8'd0, 24'd0, CLS_ZERO};
        end else if (exp_f == 8'hFF) begin
            if (frac_f == 23'd0) unpack = {x[31], 8'hFF, 1'b1, 23'd0, CLS_INF};
            else                 unpack = {x[31], 8'hFF, 1'b1, frac_f, CLS_NAN};
        end else begin
            unpack = {x[31], exp_f, 1'b1, frac_f, CLS_NORM};
        end
    endfunction

    logic [2*OW-1:0] mem_q [DEPTH];
    logic [2*OW-1:0] mem_d [DEPTH];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;
    logic [7:0]      nan_cnt_q, nan_cnt_d;

    logic [OW-1:0]   dec_a, dec_b;
    logic            accept, pop;

    assign dec_a     = unpack(a);
    assign dec_b     = unpack(b);

    // Handshake depends only on registered occupancy
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign {sa, ea, ma, fa, sb, eb, mb, fb} = mem_q[rd_ptr_q];
    assign nan_cnt = nan_cnt_q;

    // Next-state: tail write on accept, head advance on pop, NaN pair counting
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        nan_cnt_d = nan_cnt_q;
        if (accept) begin
            mem_d[wr_ptr_q] = {dec_a, dec_b};
            wr_ptr_d        = ~wr_ptr_q;
            if (((dec_a[1:0] == CLS_NAN) || (dec_b[1:0] == CLS_NAN)) && (nan_cnt_q != 8'hFF))
                nan_cnt_d = nan_cnt_q + 8'd1;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State register with synchronous reset that discards buffered entries
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            nan_cnt_q <= 8'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            nan_cnt_q <= nan_cnt_d;
        end
    end

endmodule

// File: tb/tb_fp_operand_unpack.sv
// tb/tb_fp_operand_unpack.sv - scoreboard bench for fp_operand_unpack
module tb_fp_operand_unpack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic [1:0]  fa, fb;
    logic [7:0]  nan_cnt;

    int checks = 0;
    int errors = 0;
    int model_nan = 0;
    logic [69:0] exp_q [$];

    fp_operand_unpack dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sa(sa), .sb(sb), .ea(ea), .eb(eb), .ma(ma), .mb(mb),
        .fa(fa), .fb(fb), .nan_cnt(nan_cnt)
    );

    always #5 clk = ~clk;

    // Reference decode from the field rules: {sign, exp, significand, class}
    function automatic logic [34:0] ref_unpack(input logic [31:0] x);
        int unsigned e, f;
        logic s;
        s = x[31];
        e = (x / 32'h0080_0000) % 256;
        f = x % 32'h0080_0000;
        if (e == 0)        return {s, 8'd0, 24'd0, 2'b10};
        else if (e == 255) return {s, 8'd255, 24'(f + 32'h0080_0000), (f == 0) ? 2'b00 : 2'b01};
        else               return {s, 8'(e), 24'(f + 32'h0080_0000), 2'b11};
    endfunction

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 5)
            0: r[30:23] = 8'd0;
            1: begin r[30:23] = 8'hFF; r[22:0] = '0; end
            2: begin r[30:23] = 8'hFF; r[0] = 1'b1; end
            default: r[30:23] = 8'($urandom_range(1, 254));
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [69:0] got, input logic [69:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Record an accepted pair in the scoreboard and the NaN model
    task automatic record(input logic [31:0] xa, input logic [31:0] xb);
        exp_q.push_back({ref_unpack(xa), ref_unpack(xb)});
        if ((is_nan(xa) || is_nan(xb)) && model_nan < 255) model_nan++;
    endtask

    // Offer a pair at posedge+1 until accepted; returns after the accept edge
    task automatic send(input logic [31:0] xa, input logic [31:0] xb, output int waited);
        in_valid = 1'b1; a = xa; b = xb;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            chk("send_timeout", 70'(in_ready), 70'd1);
        end else begin
            record(xa, xb);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Monitor: head must match the scoreboard front whenever out_valid
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 70'(out_valid), 70'd0);
            end else begin
                chk("head", {sa, ea, ma, fa, sb, eb, mb, fb}, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int w;
        logic [31:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 70'(out_valid), 70'd0);
        chk("rst_in_ready", 70'(in_ready), 70'd1);
        chk("rst_nan_cnt", 70'(nan_cnt), 70'd0);
        chk("rst_data", {sa, ea, ma, fa, sb, eb, mb, fb}, 70'd0);

        // Class decode
        out_ready = 1'b1;
        send(32'h3F80_0000, 32'h7F80_0000, w);
        chk("dec_a", {fa, ea, ma}, {2'b11, 8'h7F, 24'h80_0000});
        chk("dec_b", {fb, eb, mb}, {2'b00, 8'hFF, 24'h80_0000});
        send(32'h8000_0001, 32'h0000_0000, w);
        chk("denorm_a", {sa, fa, ea, ma}, {1'b1, 2'b10, 8'd0, 24'd0});

        // NaN path
        send(32'h7FC0_0000, 32'h7F80_0001, w);
        chk("nan_cls", {fa, fb, ma, mb}, {2'b01, 2'b01, 24'hC0_0000, 24'h80_0001});
        chk("nan_cnt_one", 70'(nan_cnt), 70'd1);
        @(posedge clk); #1;

        // Backpressure / full
        out_ready = 1'b0;
        send(32'h4000_0000, 32'h4040_0000, w);
        send(32'h4080_0000, 32'h40A0_0000, w);
        in_valid = 1'b1; a = 32'h40C0_0000; b = 32'h40E0_0000;
        repeat (3) begin
            chk("full_in_ready", 70'(in_ready), 70'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(32'h40C0_0000, 32'h40E0_0000, w);
        chk("full_p2_wait", 70'(w), 70'd1);

        // Simultaneous accept and pop at count=1
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'h4110_0000, 32'h4120_0000, w);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; a = 32'h4130_0000 + i; b = 32'h7F80_0000 - i;
            chk("sim_count1", {68'd0, out_valid, in_ready}, 70'b11);
            if (in_ready) record(a, b);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("sim_after", {68'd0, out_valid, in_ready}, 70'b11);

        // Randomized traffic with random backpressure and dropped offers
        for (int i = 0; i < 200; i++) begin
            out_ready = 1'($urandom);
            ra = rand_fp(); rb = rand_fp();
            in_valid = ($urandom % 4) != 0;
            a = ra; b = rb;
            if (in_valid && in_ready) record(ra, rb);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain", 70'(exp_q.size()), 70'd0);
        chk("rand_nan_cnt", 70'(nan_cnt), 70'(model_nan));

        // NaN count saturation
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1; a = 32'h7FC0_0000 | i; b = 32'h3F80_0000;
            if (in_ready) record(a, b);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("nan_sat", 70'(nan_cnt), 70'd255);
        chk("nan_sat_model", 70'(nan_cnt), 70'(model_nan));

        // Reset with a full buffer
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'h4000_0000, 32'h4000_0000, w);
        send(32'h7FC0_0001, 32'h4000_0000, w);
        chk("pre_rst_full", 70'(in_ready), 70'd0);
        rst = 1'b1;
        exp_q.delete();
        model_nan = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst", {67'd0, out_valid, in_ready, 1'b0}, {67'd0, 1'b0, 1'b1, 1'b0});
        chk("mid_rst_nan", 70'(nan_cnt), 70'd0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_operand_unpack.md
# fp_operand_unpack

Input-side counterpart of the FPU result packer: accepts pairs of IEEE-754 single-precision operands over a valid/ready handshake and splits each into sign, biased exponent, 24-bit significand with the hidden bit restored, and a 2-bit class code. The class code uses the same encoding the packer consumes. Sits between the operand source and the FPU arithmetic core. A 2-entry output buffer decouples core stalls from the source.

## Interface
Parameters:
- DEPTH, 2, output buffer entries; fixed at 2, not to be overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair a/b present.
- in_ready  out  1  block can accept a pair this cycle.
- a  in  32  operand A, IEEE-754 single.
- b  in  32  operand B, IEEE-754 single.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- sa, sb  out  1  signs.
- ea, eb  out  8  biased exponents (0 when class is zero).
- ma, mb  out  24  significands {hidden, frac}.
- fa, fb  out  2  class codes.
- nan_cnt  out  8  saturating count of accepted pairs containing a NaN.

## Operation
- Class encoding, identical to packer input:
  - 00: infinity (exp=255, frac=0).
  - 01: NaN (exp=255, frac≠0).
  - 10: zero (exp=0, any frac). Denormals are flushed to zero and keep their sign.
  - 11: normal.
- Decoded fields per class:
  - Normal: e = exp, m = {1, frac}.
  - Zero/denormal: e = 0, m = 0.
  - Inf: e = 255, m = {1, 23'b0}.
  - NaN: e = 255, m = {1, frac}.
- Sign is always passed through.
- Accept occurs when in_valid && in_ready. The decoded pair is written to the FIFO tail.
- Pop occurs when out_valid && out_ready. The head entry is removed.
- Buffer: 2-entry circular FIFO with wr_ptr, rd_ptr (1 bit each) and count (0..2).
  - in_ready = (count != 2).
  - out_valid = (count != 0).
  - Outputs always show the head entry. Entry contents are don't-care when out_valid=0, but must be stable while out_valid=1 and out_ready=0.
- Simultaneous accept and pop:
  - Count unchanged; both pointers advance.
  - Allowed at count=1.
  - At count=2 no accept occurs, because in_ready=0.
  - At count=0 no pop occurs; the accepted entry becomes visible next cycle, with no bypass.
- Pointer wrap: each 1-bit pointer toggles 1→0 naturally.
- nan_cnt: increments by 1 on each accept where fa==01 or fb==01, including when both are NaN. It saturates at 255 and holds there.

## Timing
- Reset values: count=0, wr_ptr=rd_ptr=0, nan_cnt=0, out_valid=0, in_ready=1. Data outputs reset to 0.
- Reset mid-operation discards all buffered entries. in_ready=1 in the cycle after rst deasserts.
- Latency: a pair accepted at edge N is presented with out_valid=1 after edge N (visible in cycle N+1). There is no combinational path from a/b to outputs.
- Throughput: 1 pair/cycle when out_ready is held high.
- in_ready depends only on registered count, with no combinational path from out_ready. Consequence: at count=2, a pop frees a slot only on the following cycle.
- in_valid may drop without acceptance; a/b are sampled only on accept.

## Test plan
- Reset/idle:
  - Stimulus: assert rst 2 cycles, then release.
  - Required: out_valid=0, in_ready=1, nan_cnt=0.
- Class decode, out_ready=1:
  - Stimulus: a=0x3F800000, b=0x7F800000.
  - Required, one cycle later: fa=11, ea=0x7F, ma=0x800000; fb=00, eb=0xFF, mb=0x800000.
  - Stimulus: a=0x80000001 (negative denormal).
  - Required: sa=1, fa=10, ea=0, ma=0.
- NaN path:
  - Stimulus: a=0x7FC00000, b=0x7F800001.
  - Required: fa=fb=01, ma=0xC00000, mb=0x800001, nan_cnt increments by exactly 1.
- Backpressure/full:
  - Stimulus: out_ready=0; offer 3 consecutive pairs P0, P1, P2.
  - Required: P0 and P1 accepted; in_ready=0 while P2 is offered. Head stays P0 and is stable.
  - Stimulus: raise out_ready.
  - Required: pops in order P0, P1, P2. P2 is accepted the cycle after the first pop.
- Simultaneous accept and pop:
  - Stimulus: hold count=1, in_valid=out_ready=1 for 10 cycles with distinct pairs.
  - Required: count stays 1, order is preserved, the pointers wrap 5 times each, and no entry is lost or duplicated.
- Saturation and reset mid-operation:
  - Stimulus: accept 300 NaN pairs.
  - Required: nan_cnt=255.
  - Stimulus: assert rst with count=2.
  - Required: next cycle out_valid=0, nan_cnt=0, in_ready=1.
